fphub_mult_pipe: RTL and testbench

- Pipelined HUB-format floating-point multiplier with valid/ready handshakes on input and output.
- Successor to the single-cycle start/finish HUB multiplier: adds configurable pipeline depth, one result per cycle, backpressure, and exponent overflow/underflow saturation.
- Sits between operand-issue logic and result consumers in the HUB datapath.

---
 rtl/fphub_mult_pipe.sv | 145 ++++++++++++++
 tb/tb_fphub_mult_pipe.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fphub_mult_pipe.sv
// fphub_mult_pipe: pipelined HUB floating-point multiplier with valid/ready on both sides.
// Define FPHUB_MULT_FLAGS_EN to add out_flags {invalid, overflow, underflow}.
module fphub_mult_pipe #(
  parameter int M = 23,
  parameter int E = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [E+M:0] X,
  input  logic [E+M:0] Y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [E+M:0] Z
`ifdef FPHUB_MULT_FLAGS_EN
  ,
  output logic [2:0]   out_flags
`endif
);

  localparam int W  = E + M + 1;
  localparam int N  = M + 2;
  localparam int L  = N / 2;
  localparam int H  = N - L;
  localparam int PW = 2 * N;
  localparam logic [E+1:0] BIAS = (E+2)'(1) << (E - 1);
  localparam logic [E+1:0] EMAX = (E+2)'((1 << E) - 1);

  typedef struct packed {
    logic           sgn;
    logic           zero;
    logic           inf;
`ifdef FPHUB_MULT_FLAGS_EN
    logic           inv;
`endif
    logic [E+1:0]   es;
    logic [N+H-1:0] pp_hi;
    logic [N+L-1:0] pp_lo;
  } mid_t;

  typedef struct packed {
    logic [W-1:0] z;
`ifdef FPHUB_MULT_FLAGS_EN
    logic [2:0]   flags;
`endif
  } res_t;

  function automatic mid_t decode(
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    mid_t d;
    logic [E-1:0] ex;
    logic [E-1:0] ey;
    logic [N-1:0] a;
    logic [N-1:0] b;
    ex = x[W-2:M];
    ey = y[W-2:M];
    a = {1'b1, x[M-1:0], 1'b1};
    b = {1'b1, y[M-1:0], 1'b1};
    d.sgn  = x[W-1] ^ y[W-1];
    d.zero = (ex == '0) | (ey == '0);
    d.inf  = (&ex) | (&ey);
`ifdef FPHUB_MULT_FLAGS_EN
    d.inv  = ((ex == '0) & (&ey)) | ((ey == '0) & (&ex));
`endif
    d.es   = {2'b00, ex} + {2'b00, ey} - BIAS;
    // Split multiplier so the adder tree can sit behind the first register
    d.pp_hi = {{H{1'b0}}, a} * {{N{1'b0}}, b[N-1:L]};
    d.pp_lo = {{L{1'b0}}, a} * {{N{1'b0}}, b[L-1:0]};
    return d;
  endfunction

  function automatic res_t finish(input mid_t d);
    res_t         r;
    logic [M+1:0] p_top;
    logic [M+1:0] p_lsb_unused;
    logic [E+1:0] es;
    logic [M-1:0] mant;
    logic         ovf;
    logic         unf;
    {p_top, p_lsb_unused} = {d.pp_hi, {L{1'b0}}}
                          + {{H{1'b0}}, d.pp_lo};
    es   = d.es + {{(E+1){1'b0}}, p_top[M+1]};
    mant = p_top[M+1] ? p_top[M:1] : p_top[M-1:0];
    ovf  = ~es[E+1] & (es >= EMAX);
    unf  = es[E+1] | (es == '0);
    r.z  = {d.sgn, es[E-1:0], mant};
    if (d.inf || (!d.zero && ovf))
      r.z = {d.sgn, {E{1'b1}}, {M{1'b0}}};
    else if (d.zero || unf)
      r.z = {d.sgn, {(E+M){1'b0}}};
`ifdef FPHUB_MULT_FLAGS_EN
    r.flags = (d.inf | d.zero) ? {d.inv, 2'b00}
                               : {1'b0, ovf, unf};
`endif
    return r;
  endfunction

  logic              stall;
  logic [STAGES-1:0] v;
  res_t              res_q;

  assign out_valid = v[STAGES-1];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign Z         = res_q.z;
`ifdef FPHUB_MULT_FLAGS_EN
  assign out_flags = out_valid ? res_q.flags : 3'b000;
`endif

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)
      v <= '0;
    else if (!stall)
      v <= (v << 1) | STAGES'(in_valid);
  end

  generate
    if (STAGES == 1) begin : g_one
      always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)
          res_q <= '0;
        else if (!stall)
          res_q <= finish(decode(X, Y));
      end
    end else begin : g_multi
      mid_t [STAGES-2:0] mid;
      always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
          mid   <= '0;
          res_q <= '0;
        end else if (!stall) begin
          mid[0] <= decode(X, Y);
          for (int i = 1; i < STAGES - 1; i++)
            mid[i] <= mid[i-1];
          res_q <= finish(mid[STAGES-2]);
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fphub_mult_pipe.sv
// tb_fphub_mult_pipe: scoreboard bench for the pipelined HUB multiplier.
// Directed vectors, a stalled stream, random traffic and mid-flight reset.
module tb_fphub_mult_pipe;

  localparam int E      = 8;
  localparam int M      = 23;
  localparam int STAGES = 2;
  localparam int W      = E + M + 1;
  localparam int BIAS   = 1 << (E - 1);
  localparam int EMAX   = (1 << E) - 1;
  localparam int ND     = 11;

  logic         clk = 1'b0;
  logic         rst_l = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] X = '0;
  logic [W-1:0] Y = '0;
  logic [W-1:0] Z;
`ifdef FPHUB_MULT_FLAGS_EN
  logic [2:0]   out_flags;
`endif

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] z;
    logic [2:0]   f;
    int           acc;
    bit           lat;
  } exp_t;

  exp_t sb[$];

  // Directed vectors: operands, expected Z and flags
  logic [W-1:0] dx [ND] = '{32'h40000000, 32'h407FFFFF, 32'h7F000000,
                            32'h00800000, 32'h80000000, 32'h00000000,
                            32'h3F800000, 32'h5F800000, 32'h60000000,
                            32'h5FFFFFFF, 32'h20800000};
  logic [W-1:0] dy [ND] = '{32'h40000000, 32'h407FFFFF, 32'hFF000000,
                            32'h00800000, 32'h7F800000, 32'h3F800000,
                            32'h3F800000, 32'h5F800000, 32'h5F800000,
                            32'h5FFFFFFF, 32'h20000000};
  logic [W-1:0] dz [ND] = '{32'h40000001, 32'h40FFFFFF, 32'hFF800000,
                            32'h00000000, 32'hFF800000, 32'h00000000,
                            32'h3F000001, 32'h7F000001, 32'h7F800000,
                            32'h7F800000, 32'h00800001};
  logic [2:0]   df [ND] = '{3'b000, 3'b000, 3'b010, 3'b001, 3'b100, 3'b000,
                            3'b000, 3'b000, 3'b010, 3'b010, 3'b000};

  fphub_mult_pipe #(.M(M), .E(E), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Z         (Z)
`ifdef FPHUB_MULT_FLAGS_EN
    ,
    .out_flags (out_flags)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Reference: full integer product of the HUB significands
  function automatic logic [W+2:0] ref_mul(input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    int ex, ey, e;
    bit s, zx, zy, ix, iy;
    longint a, b, p, mant;
    logic [W-1:0] z;
    logic [2:0] f;
    s  = x[W-1] ^ y[W-1];
    ex = int'(x[W-2:M]);
    ey = int'(y[W-2:M]);
    zx = (ex == 0);
    zy = (ey == 0);
    ix = (ex == EMAX);
    iy = (ey == EMAX);
    if (ix || iy) begin
      f = (zx || zy) ? 3'b100 : 3'b000;
      z = {s, {E{1'b1}}, {M{1'b0}}};
    end else if (zx || zy) begin
      f = 3'b000;
      z = {s, {(E+M){1'b0}}};
    end else begin
      a = (longint'(1) << (M + 1)) + (longint'(x[M-1:0]) << 1) + 1;
      b = (longint'(1) << (M + 1)) + (longint'(y[M-1:0]) << 1) + 1;
      p = a * b;
      e = ex + ey - BIAS;
      if (p >= (longint'(1) << (2 * M + 3))) begin
        e++;
        mant = p >> (M + 3);
      end else begin
        mant = p >> (M + 2);
      end
      mant = mant & ((longint'(1) << M) - 1);
      if (e >= EMAX) begin
        f = 3'b010;
        z = {s, {E{1'b1}}, {M{1'b0}}};
      end else if (e <= 0) begin
        f = 3'b001;
        z = {s, {(E+M){1'b0}}};
      end else begin
        f = 3'b000;
        z = {s, e[E-1:0], mant[M-1:0]};
      end
    end
    return {f, z};
  endfunction

  function automatic logic [W-1:0] rnd_op();
    int r;
    logic [E-1:0] e;
    r = $urandom_range(0, 15);
    if (r == 0)      e = '0;
    else if (r == 1) e = '1;
    else if (r == 2) e = E'($urandom_range(1, 12));
    else if (r == 3) e = E'($urandom_range(240, 254));
    else             e = E'($urandom_range(70, 190));
    return {1'($urandom_range(0, 1)), e, M'($urandom)};
  endfunction

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] ez, input logic [2:0] ef,
                      input bit lat);
    exp_t it;
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    X = x;
    Y = y;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        it.z = ez;
        it.f = ef;
        it.acc = cyc;
        it.lat = lat;
        sb.push_back(it);
        ok = 1'b1;
      end
    end
    if (!ok) chk("accept_timeout", in_ready, 1'b1);
  endtask

  task automatic send_rnd();
    logic [W-1:0] x, y;
    logic [W+2:0] r;
    x = rnd_op();
    y = rnd_op();
    r = ref_mul(x, y);
    send(x, y, r[W-1:0], r[W+2:W], 1'b0);
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    chk("drain_left", sb.size(), 0);
  endtask

  task automatic stream8();
    fork
      begin
        for (int i = 0; i < 8; i++) send_rnd();
        idle(1);
      end
      begin
        for (int c = 1; c <= 12; c++) begin
          @(posedge clk);
          #1;
          out_ready = !(c >= 3 && c <= 6);
          if (c == 4) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 1'b0);
          end
        end
      end
    join
  endtask

  task automatic rand_run(input int n);
    bit done;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          send_rnd();
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
  endtask

  // Monitor: pops the scoreboard on every output transfer
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_z = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_l) begin
      prev_stall <= 1'b0;
    end else begin
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_z", Z, prev_z);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", out_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("z", Z, e.z);
`ifdef FPHUB_MULT_FLAGS_EN
          chk("flags", out_flags, e.f);
`endif
          if (e.lat) chk("latency", cyc - e.acc, STAGES);
        end
      end
`ifdef FPHUB_MULT_FLAGS_EN
      if (!out_valid) chk("flags_idle", out_flags, 3'b000);
`endif
      prev_stall <= out_valid && !out_ready;
      prev_z <= Z;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_z", Z, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_l = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);

    for (int i = 0; i < ND; i++) begin
      send(dx[i], dy[i], dz[i], df[i], 1'b1);
      idle(4);
    end
    drain();

    stream8();
    drain();

    rand_run(60);
    drain();

    send_rnd();
    send_rnd();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1'b1);
    rst_l = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_z", Z, '0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_l = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("post_rst_valid", out_valid, 1'b0);
    chk("post_rst_in_ready", in_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
